// File: rtl/boot_rom_copier.sv
// boot_rom_copier: copies the bootloader image from ROM into SRAM word by word,
// keeps a running 32-bit checksum, and holds the CPU in reset until the first
// copy has finished.
module boot_rom_copier #(
    parameter int          LEN_WORDS  = 2048,
    parameter logic [31:0] DST_BASE   = 32'h0004_2000,
    parameter bit          AUTO_START = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic [12:0] rom_addr,
    output logic        rom_enable,
    input  logic [31:0] rom_rdata,
    output logic        sram_valid,
    output logic [31:0] sram_addr,
    output logic [31:0] sram_wdata,
    output logic [3:0]  sram_wstrb,
    input  logic        sram_ready,
    output logic        busy,
    output logic        done,
    output logic        cpu_hold,
    output logic [31:0] checksum
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_CAPT  = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Index of the final word; idx never advances past it, so 2048 words need no wrap.
    localparam logic [10:0] LAST_IDX = 11'(LEN_WORDS - 1);

    state_t      state_r;
    state_t      state_s;
    logic        launch_s;
    logic [10:0] idx_r;
    logic        armed_r;
    logic [31:0] addr_r;
    logic [31:0] wdata_r;
    logic [31:0] sum_r;
    logic        hold_r;
    logic        accept_s;

    assign accept_s = (state_r == ST_WRITE) && sram_ready;

    // Next-state decode; launch_s marks the cycle a new run is started.
    always_comb begin
        state_s  = state_r;
        launch_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start || armed_r) begin
                    state_s  = ST_READ;
                    launch_s = 1'b1;
                end else begin
                    state_s  = ST_IDLE;
                end
            end
            ST_READ:  state_s = ST_CAPT;
            ST_CAPT:  state_s = ST_WRITE;
            ST_WRITE: begin
                if (!sram_ready) begin
                    state_s = ST_WRITE;
                end else if (idx_r == LAST_IDX) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_READ;
                end
            end
            ST_DONE: begin
                if (start) begin
                    state_s  = ST_READ;
                    launch_s = 1'b1;
                end else begin
                    state_s  = ST_DONE;
                end
            end
            default:  state_s = ST_IDLE;
        endcase
    end

    // State register, word index, captured data/address, checksum and CPU hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
            idx_r   <= 11'd0;
            armed_r <= AUTO_START;
            addr_r  <= 32'd0;
            wdata_r <= 32'd0;
            sum_r   <= 32'd0;
            hold_r  <= 1'b1;
        end else begin
            state_r <= state_s;
            if (launch_s) begin
                idx_r   <= 11'd0;
                sum_r   <= 32'd0;
                armed_r <= 1'b0;
            end else if (accept_s && (idx_r != LAST_IDX)) begin
                idx_r <= idx_r + 11'd1;
            end
            if (state_r == ST_CAPT) begin
                wdata_r <= rom_rdata;
                sum_r   <= sum_r + rom_rdata;
                addr_r  <= DST_BASE + {19'd0, idx_r, 2'b00};
            end
            // Once released the CPU stays out of reset across later runs.
            if (state_s == ST_DONE) begin
                hold_r <= 1'b0;
            end
        end
    end

    // Strobes and status are decoded from state; data-path outputs come from registers.
    assign rom_enable = (state_r == ST_READ);
    assign rom_addr   = {idx_r, 2'b00};
    assign sram_valid = (state_r == ST_WRITE);
    assign sram_wstrb = sram_valid ? 4'hF : 4'h0;
    assign sram_addr  = addr_r;
    assign sram_wdata = wdata_r;
    assign busy       = (state_r == ST_READ) || (state_r == ST_CAPT) || (state_r == ST_WRITE);
    assign done       = (state_r == ST_DONE);
    assign cpu_hold   = hold_r;
    assign checksum   = sum_r;

endmodule

// File: tb/tb_boot_rom_copier.sv
// Directed bench for boot_rom_copier: three instances (4 words, 2 words, 2048 words).
module tb_boot_rom_copier;

    localparam logic [31:0] DST = 32'h0004_2000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: 4 words, ROM word i = A5000000+i
    logic        a_reset, a_start, a_ready, a_rom_en, a_valid, a_busy, a_done, a_hold;
    logic [12:0] a_rom_addr;
    logic [31:0] a_rom_rdata, a_addr, a_wdata, a_sum;
    logic [3:0]  a_wstrb;
    // Instance B: 2 words of FFFFFFFF
    logic        b_reset, b_start, b_ready, b_rom_en, b_valid, b_busy, b_done, b_hold;
    logic [12:0] b_rom_addr;
    logic [31:0] b_rom_rdata, b_addr, b_wdata, b_sum;
    logic [3:0]  b_wstrb;
    // Instance C: full 2048 words
    logic        c_reset, c_start, c_ready, c_rom_en, c_valid, c_busy, c_done, c_hold;
    logic [12:0] c_rom_addr;
    logic [31:0] c_rom_rdata, c_addr, c_wdata, c_sum;
    logic [3:0]  c_wstrb;

    boot_rom_copier #(.LEN_WORDS(4), .DST_BASE(DST), .AUTO_START(1'b1)) u_a (
        .clk(clk), .reset(a_reset), .start(a_start),
        .rom_addr(a_rom_addr), .rom_enable(a_rom_en), .rom_rdata(a_rom_rdata),
        .sram_valid(a_valid), .sram_addr(a_addr), .sram_wdata(a_wdata), .sram_wstrb(a_wstrb),
        .sram_ready(a_ready), .busy(a_busy), .done(a_done), .cpu_hold(a_hold), .checksum(a_sum));

    boot_rom_copier #(.LEN_WORDS(2), .DST_BASE(DST), .AUTO_START(1'b1)) u_b (
        .clk(clk), .reset(b_reset), .start(b_start),
        .rom_addr(b_rom_addr), .rom_enable(b_rom_en), .rom_rdata(b_rom_rdata),
        .sram_valid(b_valid), .sram_addr(b_addr), .sram_wdata(b_wdata), .sram_wstrb(b_wstrb),
        .sram_ready(b_ready), .busy(b_busy), .done(b_done), .cpu_hold(b_hold), .checksum(b_sum));

    boot_rom_copier #(.LEN_WORDS(2048), .DST_BASE(DST), .AUTO_START(1'b1)) u_c (
        .clk(clk), .reset(c_reset), .start(c_start),
        .rom_addr(c_rom_addr), .rom_enable(c_rom_en), .rom_rdata(c_rom_rdata),
        .sram_valid(c_valid), .sram_addr(c_addr), .sram_wdata(c_wdata), .sram_wstrb(c_wstrb),
        .sram_ready(c_ready), .busy(c_busy), .done(c_done), .cpu_hold(c_hold), .checksum(c_sum));

    // ROM models: data valid the cycle after the read strobe.
    always @(posedge clk) begin
        if (a_rom_en) a_rom_rdata <= 32'hA500_0000 + {21'd0, a_rom_addr[12:2]};
        if (b_rom_en) b_rom_rdata <= 32'hFFFF_FFFF;
        if (c_rom_en) c_rom_rdata <= {19'd0, c_rom_addr};
    end

    int errors = 0;
    int checks = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Results of one run on instance A
    logic [31:0] wa_q[$];
    logic [31:0] wd_q[$];
    int          first_valid, done_cyc, rom_cnt;
    logic [12:0] first_rom;
    bit          stall_ok, wstrb_ok, hold_hi, done_at1;
    logic [31:0] exp_addr[4];
    logic [31:0] exp_data[4];

    // Steps instance A from cycle 0 until done (cycle budget 40), driving ready/start.
    task automatic run_a(input bit kick, input int stall_word, input int stall_len, input int start_word);
        int stall_cnt;
        bit start_sent;
        logic [31:0] h_addr, h_data;
        stall_cnt = 0; start_sent = 1'b0; h_addr = 32'd0; h_data = 32'd0;
        wa_q.delete(); wd_q.delete();
        first_valid = -1; done_cyc = -1; rom_cnt = 0; first_rom = 13'h1FFF;
        stall_ok = 1'b1; wstrb_ok = 1'b1; hold_hi = 1'b0; done_at1 = 1'b1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            a_start = kick && (cyc == 0);
            a_ready = 1'b1;
            if (a_hold) hold_hi = 1'b1;
            if (cyc == 1) done_at1 = a_done;
            if (a_rom_en) begin
                if (rom_cnt == 0) first_rom = a_rom_addr;
                rom_cnt++;
            end
            if (a_valid) begin
                if (first_valid < 0) first_valid = cyc;
                if (a_wstrb !== 4'hF) wstrb_ok = 1'b0;
                if ((a_addr == DST + 32'(4 * stall_word)) && (stall_cnt < stall_len)) begin
                    if (stall_cnt == 0) begin
                        h_addr = a_addr;
                        h_data = a_wdata;
                    end else if ((a_addr !== h_addr) || (a_wdata !== h_data)) begin
                        stall_ok = 1'b0;
                    end
                    if (a_rom_en) stall_ok = 1'b0;
                    a_ready = 1'b0;
                    stall_cnt++;
                end else begin
                    wa_q.push_back(a_addr);
                    wd_q.push_back(a_wdata);
                end
                if ((start_word >= 0) && !start_sent && (a_addr == DST + 32'(4 * start_word))) begin
                    a_start = 1'b1;
                    start_sent = 1'b1;
                end
            end
            if (a_done && (cyc > 0)) begin
                done_cyc = cyc;
                break;
            end
            tick();
        end
        a_start = 1'b0;
        a_ready = 1'b1;
    endtask

    task automatic check_writes(input string tag);
        check_eq({tag, "_nwr"}, 32'(wa_q.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check_eq({tag, "_waddr"}, (i < wa_q.size()) ? wa_q[i] : 32'hDEAD_DEAD, exp_addr[i]);
            check_eq({tag, "_wdata"}, (i < wd_q.size()) ? wd_q[i] : 32'hDEAD_DEAD, exp_data[i]);
        end
    endtask

    initial begin
        int busy_cnt, wr_cnt, crom_cnt, extra_rom;
        logic [12:0] last_rom;
        logic [31:0] last_waddr;
        bit b_hit;

        exp_addr = '{32'h0004_2000, 32'h0004_2004, 32'h0004_2008, 32'h0004_200C};
        exp_data = '{32'hA500_0000, 32'hA500_0001, 32'hA500_0002, 32'hA500_0003};
        a_reset = 1'b1; b_reset = 1'b1; c_reset = 1'b1;
        a_start = 1'b0; b_start = 1'b0; c_start = 1'b0;
        a_ready = 1'b1; b_ready = 1'b1; c_ready = 1'b1;
        repeat (3) tick();

        // Reset values
        check_eq("rst_busy",  {31'd0, a_busy},     32'd0);
        check_eq("rst_done",  {31'd0, a_done},     32'd0);
        check_eq("rst_hold",  {31'd0, a_hold},     32'd1);
        check_eq("rst_valid", {31'd0, a_valid},    32'd0);
        check_eq("rst_romen", {31'd0, a_rom_en},   32'd0);
        check_eq("rst_romad", {19'd0, a_rom_addr}, 32'd0);
        check_eq("rst_addr",  a_addr,              32'd0);
        check_eq("rst_wdata", a_wdata,             32'd0);
        check_eq("rst_sum",   a_sum,               32'd0);

        // Auto-start copy, no backpressure
        a_reset = 1'b0;
        run_a(1'b0, -1, 0, -1);
        check_eq("t1_first_valid", 32'(first_valid), 32'd3);
        check_eq("t1_done_cyc",    32'(done_cyc),    32'd13);
        check_eq("t1_hold",        {31'd0, a_hold},  32'd0);
        check_eq("t1_sum",         a_sum,            32'h9400_0006);
        check_eq("t1_wstrb",       {31'd0, wstrb_ok}, 32'd1);
        check_eq("t1_romcnt",      32'(rom_cnt),     32'd4);
        check_writes("t1");

        // Backpressure: 5 stall cycles on word 1
        a_reset = 1'b1; tick(); tick();
        a_reset = 1'b0;
        run_a(1'b0, 1, 5, -1);
        check_eq("bp_done_cyc", 32'(done_cyc),     32'd18);
        check_eq("bp_stable",   {31'd0, stall_ok}, 32'd1);
        check_eq("bp_romcnt",   32'(rom_cnt),      32'd4);
        check_eq("bp_sum",      a_sum,             32'h9400_0006);
        check_writes("bp");

        // start during WRITE of word 2 is ignored
        a_reset = 1'b1; tick(); tick();
        a_reset = 1'b0;
        run_a(1'b0, -1, 0, 2);
        check_eq("sw_done_cyc", 32'(done_cyc), 32'd13);
        check_eq("sw_sum",      a_sum,         32'h9400_0006);
        check_writes("sw");

        // start in DONE: re-copy, checksum not accumulated, cpu_hold stays low
        run_a(1'b1, -1, 0, -1);
        check_eq("rd_done_drop", {31'd0, done_at1}, 32'd0);
        check_eq("rd_done_cyc",  32'(done_cyc),     32'd13);
        check_eq("rd_sum",       a_sum,             32'h9400_0006);
        check_eq("rd_hold",      {31'd0, hold_hi},  32'd0);
        check_writes("rd");

        // Reset while in CAPT of word 2 (cycle 8 of a run started from DONE)
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        repeat (7) tick();
        check_eq("mr_romad", {19'd0, a_rom_addr}, 32'h0000_0008);
        check_eq("mr_sum",   a_sum,               32'h4A00_0001);
        a_reset = 1'b1;
        tick();
        check_eq("mr_valid", {31'd0, a_valid}, 32'd0);
        check_eq("mr_busy",  {31'd0, a_busy},  32'd0);
        check_eq("mr_hold",  {31'd0, a_hold},  32'd1);
        check_eq("mr_sum0",  a_sum,            32'd0);
        a_reset = 1'b0;
        run_a(1'b0, -1, 0, -1);
        check_eq("mr_first_rom", {19'd0, first_rom}, 32'd0);
        check_eq("mr_done_cyc",  32'(done_cyc),      32'd13);
        check_writes("mr");

        // Checksum wrap with 2 words of FFFFFFFF
        b_reset = 1'b0;
        b_hit = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (b_done) begin
                b_hit = 1'b1;
                break;
            end
            tick();
        end
        check_eq("wrap_done", {31'd0, b_hit}, 32'd1);
        check_eq("wrap_sum",  b_sum,          32'hFFFF_FFFE);

        // Full 2048-word copy
        c_reset = 1'b0;
        busy_cnt = 0; wr_cnt = 0; crom_cnt = 0; extra_rom = 0;
        last_rom = 13'd0; last_waddr = 32'd0;
        for (int i = 0; i < 7000; i++) begin
            if (c_done) break;
            if (c_busy) busy_cnt++;
            if (c_rom_en) begin
                crom_cnt++;
                last_rom = c_rom_addr;
            end
            if (c_valid && c_ready) begin
                wr_cnt++;
                last_waddr = c_addr;
            end
            tick();
        end
        check_eq("full_done",     {31'd0, c_done},     32'd1);
        check_eq("full_busy",     32'(busy_cnt),       32'd6144);
        check_eq("full_writes",   32'(wr_cnt),         32'd2048);
        check_eq("full_reads",    32'(crom_cnt),       32'd2048);
        check_eq("full_last_rom", {19'd0, last_rom},   32'h0000_1FFC);
        check_eq("full_last_wr",  last_waddr,          32'h0004_3FFC);
        for (int i = 0; i < 5; i++) begin
            if (c_rom_en) extra_rom++;
            tick();
        end
        check_eq("full_no_extra", 32'(extra_rom), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/boot_rom_copier.md
Name: boot_rom_copier

Overview:
- Initiator for the bootloader ROM's read port.
- After reset (or on `start`), reads the bootloader image word by word and writes it into SRAM through a valid/ready write port.
- Computes a running 32-bit checksum of the copied words.
- Holds the CPU in reset until the copy completes, so the CPU can run the image from SRAM.

Parameters:
- LEN_WORDS, 2048: words to copy; legal range 1..2048.
- DST_BASE, 32'h0004_2000: SRAM byte address of word 0.
- AUTO_START, 1: 1 = start a copy automatically on the first IDLE cycle after reset.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; begins a copy when in IDLE or DONE
- rom_addr  out  13  ROM byte address, word aligned ({idx, 2'b00})
- rom_enable  out  1  ROM read strobe
- rom_rdata  in  32  ROM data; valid the cycle after rom_enable
- sram_valid  out  1  write request
- sram_addr  out  32  write byte address
- sram_wdata  out  32  write data
- sram_wstrb  out  4  byte strobes; always 4'hF while sram_valid=1, else 0
- sram_ready  in  1  write accepted this cycle when sram_valid=1
- busy  out  1  copy in progress
- done  out  1  copy completed; held until next start or reset
- cpu_hold  out  1  CPU reset hold; 1 until the first copy completes
- checksum  out  32  modulo-2^32 sum of words copied in the current/last run

Behaviour:
- Reset values: state=IDLE, idx=0, rom_enable=0, rom_addr=0, sram_valid=0, sram_addr=0, sram_wdata=0, busy=0, done=0, cpu_hold=1, checksum=0.
- Reset re-arms AUTO_START.
- FSM states: IDLE, READ, CAPT, WRITE, DONE.
- IDLE:
  - If start=1, or auto-start is armed: clear idx and checksum, clear auto-start arm, go to READ.
  - Otherwise stay in IDLE.
- READ: rom_enable=1, rom_addr={idx,2'b00}; next state CAPT.
- CAPT:
  - Latch rom_rdata into the sram_wdata register.
  - checksum <= checksum + rom_rdata (wraps).
  - Next state WRITE.
- WRITE:
  - sram_valid=1, sram_addr=DST_BASE+{idx,2'b00}.
  - If sram_ready=0: stay in WRITE; addr, wdata and wstrb held stable; rom_enable=0.
  - If sram_ready=1 and idx==LEN_WORDS-1: go to DONE.
  - If sram_ready=1 otherwise: idx<=idx+1, go to READ.
  - The handshake completes in the same cycle sram_valid is first asserted if sram_ready=1.
- DONE:
  - done=1, cpu_hold=0 (stays 0 until reset, including across later runs).
  - start=1 clears done and begins a new run as in IDLE.
- busy=1 in READ, CAPT and WRITE only.
- start is ignored in READ, CAPT and WRITE.
- Throughput: 3 cycles per word with sram_ready=1; each ready=0 cycle adds one cycle.
- rom_enable is asserted exactly once per word and never during a stall.
- idx is 11 bits. LEN_WORDS=2048 ends at idx=2047 with no wrap and no extra read.
- sram_addr arithmetic is 32-bit; overflow is not checked.
- Reset mid-copy: next cycle all outputs take their reset values and no partial write is retried. With AUTO_START=1 the copy restarts from idx 0.
- done, busy and the sram_valid/rom_enable strobes are decoded from state. sram_addr, sram_wdata and checksum are registers.

Test Plan:
- AUTO_START=1, LEN_WORDS=4, ROM word i = 32'hA500_0000+i, sram_ready=1; cycle 0 = first cycle with reset low (IDLE):
  - Writes of 0xA5000000..0xA5000003 to 0x42000, 0x42004, 0x42008, 0x4200C.
  - First sram_valid at cycle 3.
  - done=1 and cpu_hold=0 at cycle 13.
  - checksum=0x94000006.
- Backpressure: hold sram_ready=0 for 5 cycles on word 1 -> sram_valid stays 1 with addr 0x42004 and data 0xA5000001 stable; rom_enable=0 throughout; done is delayed by exactly 5 cycles.
- start pulsed during WRITE of word 2 -> ignored, run unchanged. start pulsed in DONE -> done drops next cycle, full re-copy runs, checksum ends at 0x94000006 again (not accumulated), cpu_hold stays 0.
- reset asserted while in CAPT of word 2 -> next cycle: sram_valid=0, busy=0, cpu_hold=1, checksum=0. After release the copy restarts at rom_addr 0 and all 4 words are rewritten.
- Checksum wrap: LEN_WORDS=2, ROM words 0xFFFFFFFF, 0xFFFFFFFF -> checksum=0xFFFFFFFE.
- LEN_WORDS=2048, sram_ready=1:
  - Last read rom_addr=0x1FFC, last write sram_addr=0x43FFC.
  - Exactly 2048 writes; done after 6144 cycles of busy.
  - No rom_enable after the last read.
